minutes_hours_counter: RTL and testbench

MINUTES_HOURS_COUNTER -- requirements
Module: minutes_hours_counter

---
 rtl/minutes_hours_counter.sv | 161 ++++++++++++++++
 tb/tb_minutes_hours_counter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minutes_hours_counter.sv
// Minutes/hours timekeeping block for a digital clock.
// Keeps binary minutes (0..59) and hours (0..23) advanced by the seconds
// counter's inc_mins request, offers a three-state set mode driven by two
// debounced buttons, and presents BCD digits in 24-hour or 12-hour format.
module minutes_hours_counter (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       inc_mins,
  input  logic       mode_12h,
  input  logic       btn_set,
  input  logic       btn_up,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic       pm,
  output logic       set_hrs_active,
  output logic       set_mins_active,
  output logic       day_tick
);

  // Set-mode sequencing: RUN -> SET_HRS -> SET_MINS -> RUN on each btn_set press.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HRS  = 2'd1,
    SET_MINS = 2'd2
  } state_t;

  localparam logic [5:0] MIN_LAST = 6'd59;
  localparam logic [4:0] HR_LAST  = 5'd23;
  localparam logic [4:0] HR_NOON  = 5'd12;

  state_t     state_reg, state_next;
  logic [5:0] minutes_reg, minutes_next;
  logic [4:0] hours_reg, hours_next;
  logic       btn_set_prev_reg, btn_up_prev_reg;

  logic       set_event;
  logic       up_event;
  logic [4:0] display_hour;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;

  // Binary 0..59 to two BCD digits.
  function automatic logic [7:0] to_bcd(input logic [5:0] value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 6'd10);
    ones = 4'(value % 6'd10);
    return {tens, ones};
  endfunction

  // Minute advance with wrap; values at or above the top are folded to 0 so
  // a corrupted counter can never stay out of range.
  function automatic logic [5:0] next_minute(input logic [5:0] value);
    return (value >= MIN_LAST) ? 6'd0 : value + 6'd1;
  endfunction

  // Hour advance with wrap, same out-of-range folding as minutes.
  function automatic logic [4:0] next_hour(input logic [4:0] value);
    return (value >= HR_LAST) ? 5'd0 : value + 5'd1;
  endfunction

  // A button event is a 0 -> 1 transition between consecutive clock edges;
  // holding a button gives exactly one event.
  assign set_event = btn_set & ~btn_set_prev_reg;
  assign up_event  = btn_up  & ~btn_up_prev_reg;

  // State, time and button-history registers with asynchronous reset.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_reg        <= RUN;
      minutes_reg      <= 6'd0;
      hours_reg        <= 5'd0;
      btn_set_prev_reg <= 1'b0;
      btn_up_prev_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      minutes_reg      <= minutes_next;
      hours_reg        <= hours_next;
      btn_set_prev_reg <= btn_set;
      btn_up_prev_reg  <= btn_up;
    end
  end

  // Next-state and time update. The btn_up action is applied to the field
  // owned by the current state before a simultaneous btn_set moves the state,
  // and inc_mins is only honoured in RUN so the time freezes while setting.
  always_comb begin
    state_next   = state_reg;
    minutes_next = minutes_reg;
    hours_next   = hours_reg;
    case (state_reg)
      RUN: begin
        if (inc_mins) begin
          minutes_next = next_minute(minutes_reg);
          if (minutes_reg >= MIN_LAST) begin
            hours_next = next_hour(hours_reg);
          end
        end
        if (set_event) begin
          state_next = SET_HRS;
        end
      end
      SET_HRS: begin
        if (up_event) begin
          hours_next = next_hour(hours_reg);
        end
        if (set_event) begin
          state_next = SET_MINS;
        end
      end
      SET_MINS: begin
        // Minute setting never carries into hours.
        if (up_event) begin
          minutes_next = next_minute(minutes_reg);
        end
        if (set_event) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Display hour selection: 12-hour format maps 0 -> 12 and 13..23 -> 1..11;
  // only the display is affected, never the stored hour.
  always_comb begin
    display_hour = hours_reg;
    if (mode_12h) begin
      if (hours_reg == 5'd0) begin
        display_hour = HR_NOON;
      end else if (hours_reg > HR_NOON) begin
        display_hour = hours_reg - HR_NOON;
      end
    end
  end

  // BCD digit outputs straight from the registered counters.
  always_comb begin
    min_bcd  = to_bcd(minutes_reg);
    hr_bcd   = to_bcd({1'b0, display_hour});
    min_tens = min_bcd[7:4];
    min_ones = min_bcd[3:0];
    hr_tens  = hr_bcd[7:4];
    hr_ones  = hr_bcd[3:0];
  end

  // Status outputs: pm from the 24-hour value, set-mode flags for blanking,
  // and a combinational end-of-day pulse aligned with the final minute advance.
  always_comb begin
    pm              = (hours_reg >= HR_NOON);
    set_hrs_active  = (state_reg == SET_HRS);
    set_mins_active = (state_reg == SET_MINS);
    day_tick        = (state_reg == RUN) && (minutes_reg == MIN_LAST) &&
                      (hours_reg == HR_LAST) && inc_mins;
  end

endmodule

// File: tb/tb_minutes_hours_counter.sv
// Testbench for minutes_hours_counter: directed scenarios plus random
// stimulus, checked against a time-of-day model kept in minutes since midnight.
module tb_minutes_hours_counter;

  logic       clk_1Hz = 1'b0;
  logic       reset;
  logic       inc_mins;
  logic       mode_12h;
  logic       btn_set;
  logic       btn_up;
  logic [3:0] min_ones, min_tens, hr_ones, hr_tens;
  logic       pm, set_hrs_active, set_mins_active, day_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tod = minutes since midnight, mode 0=run 1=hours 2=mins.
  int tod;
  int mode;
  int set_prev;
  int up_prev;

  minutes_hours_counter dut (
    .clk_1Hz         (clk_1Hz),
    .reset           (reset),
    .inc_mins        (inc_mins),
    .mode_12h        (mode_12h),
    .btn_set         (btn_set),
    .btn_up          (btn_up),
    .min_ones        (min_ones),
    .min_tens        (min_tens),
    .hr_ones         (hr_ones),
    .hr_tens         (hr_tens),
    .pm              (pm),
    .set_hrs_active  (set_hrs_active),
    .set_mins_active (set_mins_active),
    .day_tick        (day_tick)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // Expected {min_tens,min_ones,hr_tens,hr_ones,pm,set_hrs,set_mins}.
  function automatic logic [18:0] exp_vec(input logic fmt12);
    int m, h, dh;
    m = tod % 60;
    h = tod / 60;
    if (fmt12) begin
      dh = h % 12;
      if (dh == 0) dh = 12;
    end else begin
      dh = h;
    end
    return {4'(m / 10), 4'(m % 10), 4'(dh / 10), 4'(dh % 10),
            (h >= 12), (mode == 1), (mode == 2)};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {min_tens, min_ones, hr_tens, hr_ones, pm, set_hrs_active, set_mins_active};
  endfunction

  function automatic logic exp_tick();
    return (mode == 0) && (tod == 1439) && inc_mins;
  endfunction

  task automatic model_reset();
    tod = 0; mode = 0; set_prev = 0; up_prev = 0;
  endtask

  // One clock edge: model consumes the current inputs, then the DUT is sampled 2 units later.
  task automatic cycle();
    int se, ue;
    se = (btn_set && set_prev == 0) ? 1 : 0;
    ue = (btn_up && up_prev == 0) ? 1 : 0;
    case (mode)
      0: if (inc_mins) tod = (tod + 1) % 1440;
      1: if (ue != 0) tod = ((tod / 60 + 1) % 24) * 60 + tod % 60;
      default: if (ue != 0) tod = (tod / 60) * 60 + (tod % 60 + 1) % 60;
    endcase
    if (se != 0) mode = (mode + 1) % 3;
    set_prev = btn_set ? 1 : 0;
    up_prev  = btn_up ? 1 : 0;
    @(posedge clk_1Hz);
    #2;
  endtask

  task automatic press_set();
    btn_set = 1'b1; cycle();
    btn_set = 1'b0; cycle();
  endtask

  task automatic press_up();
    btn_up = 1'b1; cycle();
    btn_up = 1'b0; cycle();
  endtask

  // From RUN, walk the set FSM to hh:mm and return to RUN.
  task automatic goto_time(input int h, input int m);
    press_set();
    while (tod / 60 != h) press_up();
    press_set();
    while (tod % 60 != m) press_up();
    press_set();
  endtask

  task automatic test_reset();
    reset = 1'b1; inc_mins = 1'b0; mode_12h = 1'b0; btn_set = 1'b0; btn_up = 1'b0;
    model_reset();
    @(posedge clk_1Hz); #2;
    n_checks++;
    if (obs_vec() !== 19'd0) begin
      n_fail++; $display("FAIL reset_24h: got %h expected %h", obs_vec(), 19'd0);
    end
    mode_12h = 1'b1; inc_mins = 1'b1; #1;
    n_checks++;
    if ({hr_tens, hr_ones} !== 8'h12) begin
      n_fail++; $display("FAIL reset_12h_hour: got %h expected 12", {hr_tens, hr_ones});
    end
    n_checks++;
    if (day_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_day_tick: got %b expected 0", day_tick);
    end
    mode_12h = 1'b0; inc_mins = 1'b0;
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_run_count();
    for (int i = 0; i < 60; i++) begin
      inc_mins = 1'b1; cycle();
      inc_mins = 1'b0; cycle();
      n_checks++;
      if (obs_vec() !== exp_vec(1'b0)) begin
        n_fail++; $display("FAIL run_count step %0d: got %h expected %h", i, obs_vec(), exp_vec(1'b0));
      end
    end
    n_checks++;
    if (obs_vec() !== {4'd0, 4'd0, 4'd0, 4'd1, 3'b000}) begin
      n_fail++; $display("FAIL run_count_final: got %h expected 01:00 run", obs_vec());
    end
    $display("test_run_count done at %0d%0d:%0d%0d", hr_tens, hr_ones, min_tens, min_ones);
  endtask

  task automatic test_day_rollover();
    goto_time(23, 59);
    inc_mins = 1'b1; #1;
    n_checks++;
    if (day_tick !== 1'b1) begin
      n_fail++; $display("FAIL day_tick_before: got %b expected 1", day_tick);
    end
    cycle();
    n_checks++;
    if (obs_vec() !== 19'd0) begin
      n_fail++; $display("FAIL day_rollover: got %h expected 00:00 am run", obs_vec());
    end
    n_checks++;
    if (day_tick !== 1'b0) begin
      n_fail++; $display("FAIL day_tick_after: got %b expected 0", day_tick);
    end
    inc_mins = 1'b0;
    $display("test_day_rollover done");
  endtask

  task automatic test_12h_display();
    int hrs[6]  = '{0, 1, 11, 12, 13, 23};
    int d12[6]  = '{12, 1, 11, 12, 1, 11};
    int pms[6]  = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      goto_time(hrs[i], 0);
      mode_12h = 1'b1; #1;
      n_checks++;
      if ({hr_tens, hr_ones, pm} !== {4'(d12[i] / 10), 4'(d12[i] % 10), pms[i] != 0}) begin
        n_fail++; $display("FAIL disp12 hour %0d: got %0d%0d pm=%b expected %0d pm=%0d",
                           hrs[i], hr_tens, hr_ones, pm, d12[i], pms[i]);
      end
      mode_12h = 1'b0; #1;
      n_checks++;
      if ({hr_tens, hr_ones, pm} !== {4'(hrs[i] / 10), 4'(hrs[i] % 10), pms[i] != 0}) begin
        n_fail++; $display("FAIL disp24 hour %0d: got %0d%0d pm=%b expected %0d", hrs[i],
                           hr_tens, hr_ones, pm, hrs[i]);
      end
      $display("display hour %0d: 12h=%0d 24h=%0d%0d", hrs[i], d12[i], hr_tens, hr_ones);
    end
  endtask

  task automatic test_set_mins_wrap();
    goto_time(7, 59);
    press_set(); press_set();
    n_checks++;
    if (obs_vec() !== {4'd5, 4'd9, 4'd0, 4'd7, 3'b001}) begin
      n_fail++; $display("FAIL set_mins_entry: got %h expected 07:59 set_mins", obs_vec());
    end
    press_up();
    n_checks++;
    if (obs_vec() !== {4'd0, 4'd0, 4'd0, 4'd7, 3'b001}) begin
      n_fail++; $display("FAIL set_mins_wrap: got %h expected 07:00 set_mins", obs_vec());
    end
    btn_up = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    btn_up = 1'b0; cycle();
    n_checks++;
    if ({min_tens, min_ones, hr_tens, hr_ones} !== 16'h0107) begin
      n_fail++; $display("FAIL hold_up_single: got %h expected 0107", {min_tens, min_ones, hr_tens, hr_ones});
    end
    press_set();
    $display("test_set_mins_wrap done");
  endtask

  task automatic test_set_hrs_freeze();
    press_set();
    inc_mins = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec(1'b0)) begin
        n_fail++; $display("FAIL set_hrs_freeze %0d: got %h expected %h", i, obs_vec(), exp_vec(1'b0));
      end
    end
    btn_set = 1'b1; btn_up = 1'b1; cycle();
    n_checks++;
    if (obs_vec() !== {4'd0, 4'd1, 4'd0, 4'd8, 3'b001}) begin
      n_fail++; $display("FAIL set_and_up: got %h expected 08:01 set_mins", obs_vec());
    end
    inc_mins = 1'b0; btn_set = 1'b0; btn_up = 1'b0; cycle();
    press_set();
    $display("test_set_hrs_freeze done");
  endtask

  task automatic test_async_reset();
    goto_time(12, 34);
    press_set(); press_set();
    n_checks++;
    if (obs_vec() !== {4'd3, 4'd4, 4'd1, 4'd2, 3'b101}) begin
      n_fail++; $display("FAIL pre_reset: got %h expected 12:34 pm set_mins", obs_vec());
    end
    #2; reset = 1'b1; btn_set = 1'b1; #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== 19'd0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 00:00 run", obs_vec());
    end
    @(posedge clk_1Hz); #2;
    reset = 1'b0;
    cycle();
    n_checks++;
    if (obs_vec() !== exp_vec(1'b0) || set_hrs_active !== 1'b1) begin
      n_fail++; $display("FAIL held_btn_after_reset: got %h expected %h", obs_vec(), exp_vec(1'b0));
    end
    cycle();
    n_checks++;
    if (set_hrs_active !== 1'b1) begin
      n_fail++; $display("FAIL held_btn_no_repeat: got set_hrs=%b expected 1", set_hrs_active);
    end
    btn_set = 1'b0; cycle();
    press_set(); press_set();
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      inc_mins = ($urandom_range(0, 3) != 0);
      btn_set  = ($urandom_range(0, 7) == 0);
      btn_up   = ($urandom_range(0, 2) == 0);
      mode_12h = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; #1;
        model_reset();
        @(posedge clk_1Hz); #2;
        reset = 1'b0;
      end
      #1;
      n_checks++;
      if (day_tick !== exp_tick()) begin
        n_fail++; $display("FAIL random_day_tick %0d: got %b expected %b", i, day_tick, exp_tick());
      end
      cycle();
      n_checks++;
      if (obs_vec() !== exp_vec(mode_12h)) begin
        n_fail++; $display("FAIL random %0d: got %h expected %h", i, obs_vec(), exp_vec(mode_12h));
      end
    end
    btn_set = 1'b0; btn_up = 1'b0; inc_mins = 1'b0; mode_12h = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_day_rollover();
    test_12h_display();
    test_set_mins_wrap();
    test_set_hrs_freeze();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
